// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_pkg;

    localparam int unsigned SA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Purely combinational 1-bit full adder used by the serial adder datapath.
module full_adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    always_comb begin
        s_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: captures operands, shifts them LSB-first through a full adder.
// Optional subtract mode (sub_i port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             shift_en_o,
    output logic             bit_o,
    output logic             carry_o,
    output logic             done_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s, fa_cout;

    full_adder_1bit u_fa (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .cout_o(fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        busy_o     = 1'b0;
        shift_en_o = 1'b0;
        bit_o      = 1'b0;
        carry_o    = 1'b0;
        done_o     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_i;
                    carry_d = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    // A - B as A + ~B + 1
                    if (sub_i) begin
                        b_sr_d  = ~b_i;
                        carry_d = 1'b1;
                    end
`endif
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_o     = 1'b1;
                shift_en_o = 1'b1;
                bit_o      = fa_s;
                carry_o    = fa_cout;
                a_sr_d     = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d     = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d    = fa_cout;
                // Counter stops at WIDTH-1; it is reloaded on the next start.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl; compares against plain-arithmetic sums.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract mode.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy, shift_en, bit_s, carry_s, done;

    logic [W:0]   res;
    int           checks = 0;
    int           errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i     (sub),
`endif
        .a_i       (a_in),
        .b_i       (b_in),
        .busy_o    (busy),
        .shift_en_o(shift_en),
        .bit_o     (bit_s),
        .carry_o   (carry_s),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream result register: {carry_o, bit_o} loaded each enabled cycle.
    always @(posedge clk) begin
        if (shift_en) begin
            res <= {carry_s, bit_s, res[W-1:1]};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input bit inject, input string tag);
        logic [W-1:0]     bb;
        logic [W-1:0]     exp_c, got_b, got_c;
        logic [W:0]       exp_res;
        longint unsigned  cin, mask, part;
        int               shifts, done_cnt, done_at;

        bb   = s ? ~b : b;
        cin  = s ? 64'd1 : 64'd0;
        part = longint'(a) + longint'(bb) + cin;
        exp_res = part[W:0];
        for (int i = 0; i < int'(W); i++) begin
            mask     = (64'd1 << (i + 1)) - 64'd1;
            part     = (longint'(a) & mask) + (longint'(bb) & mask) + cin;
            exp_c[i] = part[i+1];
        end

        shifts   = 0;
        done_cnt = 0;
        done_at  = 0;
        got_b    = '0;
        got_c    = '0;

        @(negedge clk);
        a_in  = a;
        b_in  = b;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = s;
`endif
        start = 1'b1;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            if (shift_en) begin
                if (shifts < int'(W)) begin
                    got_b[shifts] = bit_s;
                    got_c[shifts] = carry_s;
                end
                shifts++;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (k == 1) start = 1'b0;
            if (inject && k == 3) begin
                start = 1'b1;
                a_in  = '1;
                b_in  = '1;
            end
            if (inject && k == 4) start = 1'b0;
        end
        check({tag, " shifts"},  64'(shifts),   64'(W));
        check({tag, " done_at"}, 64'(done_at),  64'(W + 1));
        check({tag, " done_n"},  64'(done_cnt), 64'd1);
        check({tag, " busy"},    64'(busy),     64'd1);
        check({tag, " bits"},    64'(got_b),    64'(exp_res[W-1:0]));
        check({tag, " carries"}, 64'(got_c),    64'(exp_c));
        check({tag, " result"},  64'(res),      64'(exp_res));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #1;
        check("rst busy",     64'(busy),     64'd0);
        check("rst shift_en", 64'(shift_en), 64'd0);
        check("rst bit",      64'(bit_s),    64'd0);
        check("rst carry",    64'(carry_s),  64'd0);
        check("rst done",     64'(done),     64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "5a+3c");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ff+01");
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "ff+ff");
        run_op(8'h00, 8'h00, 1'b0, 1'b0, "00+00");
        run_op(8'h12, 8'h34, 1'b0, 1'b1, "12+34 inj");

        // Reset in the middle of an operation
        @(negedge clk);
        a_in  = 8'hAA;
        b_in  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy",     64'(busy),     64'd0);
        check("midrst shift_en", 64'(shift_en), 64'd0);
        check("midrst bit",      64'(bit_s),    64'd0);
        check("midrst carry",    64'(carry_s),  64'd0);
        check("midrst done",     64'(done),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clk);
            check("midrst no done", 64'(done), 64'd0);
        end
        run_op(8'h01, 8'h01, 1'b0, 1'b0, "01+01");

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 1'b0, "10-01");
        run_op(8'h01, 8'h02, 1'b1, 1'b0, "01-02");
`endif

        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] ra, rb;
            bit           rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            run_op(ra, rb, rs, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
